data_router_seq: RTL

//  Sequencer for data_router. Walks one input tile channel by channel.
//  - Issues line-buffer row fetches (bank/row/col) through a req/gnt handshake.
//  - Rotates the router's row-pointer select (rpsel) as the window slides.
//  - Waits for each depthwise/pointwise PE pass to finish (dwpe_ena high->low).
//  - Pulses blkend at the end of each channel block and done at the end of the tile.

---
 rtl/data_router_pkg.sv | 19 +
 rtl/data_router_seq_rptr.sv | 18 +
 rtl/data_router_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/data_router_pkg.sv
// data_router_pkg: shared sizing, FSM state and tile config types for the data_router sequencer
package data_router_pkg;
    localparam int STRIDE = 2;
    localparam int KSIZE  = 3;
    // the line buffer must hold a whole kernel window
    localparam int BUFH   = (STRIDE + 1 > KSIZE) ? STRIDE + 1 : KSIZE;
    localparam int BW     = 8;
    localparam int RW     = 8;
    localparam int CW     = 28;

    typedef enum logic [2:0] {IDLE, FILL, WAITH, WAITL, SLIDE, BEND, FIN} seq_state_e;

    typedef struct packed {
        logic          dw;
        logic [BW-1:0] nch;
        logic [RW-1:0] nstep;
        logic [CW-1:0] col;
    } seq_cfg_t;
endpackage

// File: rtl/data_router_seq_rptr.sv
// rptr_mod: advances the buffer row-pointer select modulo the line-buffer height
//   rpsel  in   current window-top buffer row
//   inc    in   rows the window slid by
//   nxt    out  (rpsel + inc) mod BUFH
module rptr_mod
    import data_router_pkg::*;
(
    input  logic [1:0] rpsel,
    input  logic [1:0] inc,
    output logic [1:0] nxt
);
    logic [2:0] sum;

    always_comb begin
        sum = {1'b0, rpsel} + {1'b0, inc};
        nxt = 2'(sum >= 3'(BUFH) ? sum - 3'(BUFH) : sum);
    end
endmodule

// File: rtl/data_router_seq.sv
// data_router_seq: walks one tile channel by channel, fetching line-buffer rows and pacing PE passes
//   clk, rst                       clock, async active-high reset
//   start, cfg_dw/nch/nstep/col    tile start pulse and config latched on it
//   rd_req, rd_gnt                 row-fetch handshake; bank/row/col describe the fetch
//   rpsel                          buffer row holding the window top
//   dw_comp                        latched depthwise mode
//   dwpe_ena                       PE pass active
//   blkend, busy, done             end-of-block pulse, tile in progress, end-of-tile pulse
module data_router_seq
    import data_router_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cfg_dw,
    input  logic [BW-1:0] cfg_nch,
    input  logic [RW-1:0] cfg_nstep,
    input  logic [CW-1:0] cfg_col,
    output logic          rd_req,
    input  logic          rd_gnt,
    output logic [BW-1:0] bank,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [1:0]    rpsel,
    output logic          dw_comp,
    input  logic          dwpe_ena,
    output logic          blkend,
    output logic          busy,
    output logic          done
);
    seq_state_e    state;
    seq_cfg_t      cfg;
    logic [RW-1:0] step;
    logic [1:0]    cnt, last, inc, rp_nxt;
    logic          gnt, phase_end;

    assign inc       = cfg.dw ? 2'(STRIDE) : 2'd1;
    // FILL loads the whole buffer in DW mode, SLIDE only brings in the stride rows
    assign last      = state == FILL ? (cfg.dw ? 2'(BUFH - 1) : 2'd0) : inc - 2'd1;
    assign rd_req    = state == FILL || state == SLIDE;
    assign gnt       = rd_req && rd_gnt;
    assign phase_end = gnt && cnt == last;
    assign blkend    = state == BEND;
    assign done      = state == FIN;
    assign busy      = state != IDLE && state != FIN;
    assign col       = cfg.col;
    assign dw_comp   = cfg.dw;

    rptr_mod u_rptr (.rpsel(rpsel), .inc(inc), .nxt(rp_nxt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cfg   <= '0;
            bank  <= '0;
            row   <= '0;
            step  <= '0;
            rpsel <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= FILL;
                    cfg.dw    <= cfg_dw;
                    cfg.nch   <= cfg_nch == '0 ? BW'(1) : cfg_nch;
                    cfg.nstep <= cfg_nstep == '0 ? RW'(1) : cfg_nstep;
                    cfg.col   <= cfg_col;
                    bank      <= '0;
                    row       <= '0;
                    step      <= '0;
                    rpsel     <= '0;
                    cnt       <= '0;
                end
                FILL, SLIDE: if (gnt) begin
                    row <= row + 1'b1;
                    cnt <= phase_end ? 2'd0 : cnt + 2'd1;
                    if (phase_end) begin
                        state <= WAITH;
                        if (state == SLIDE && cfg.dw) rpsel <= rp_nxt;
                    end
                end
                WAITH: if (dwpe_ena) state <= WAITL;
                WAITL: if (!dwpe_ena) begin
                    step  <= step + 1'b1;
                    state <= step + 1'b1 < cfg.nstep ? SLIDE : BEND;
                end
                BEND: begin
                    bank  <= bank + 1'b1;
                    row   <= '0;
                    step  <= '0;
                    rpsel <= '0;
                    state <= bank + 1'b1 < cfg.nch ? FILL : FIN;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
